mem_wb_stage: RTL

Parametrised MEM→WB pipeline stage for the 16-bit CPU. It replaces the bare always-enabled pipeline latch with:
- a valid/ready handshake and a two-entry skid buffer, so writeback back-pressure never drops an instruction;
- a synchronous flush;
- a write-back data select, so the register-file port sees one result word;
- a forwarding tap toward the execute stage.

---
 rtl/mem_wb_stage.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline stage: valid/ready handshake with a two-entry skid buffer,
// synchronous flush, write-back data select and a forwarding tap.
module mem_wb_stage #(
   parameter int DATA_W  = 16,
   parameter int RADDR_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush_in,
   input  logic               valid_in,
   output logic               ready_out,
   input  logic               wbs_in,
   input  logic [DATA_W-1:0]  memData_in,
   input  logic [DATA_W-1:0]  calcData_in,
   input  logic [RADDR_W-1:0] reg_dest_in,
   input  logic               wre_in,
   output logic               valid_out,
   input  logic               ready_in,
   output logic [DATA_W-1:0]  wb_data_out,
   output logic [RADDR_W-1:0] reg_dest_out,
   output logic               wre_out,
   output logic               fwd_valid_out,
   output logic [RADDR_W-1:0] fwd_reg_out,
   output logic [DATA_W-1:0]  fwd_data_out,
   output logic [1:0]         occupancy_out
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [DATA_W-1:0]    head_data_q, head_data_d;
   logic [RADDR_W-1:0]   head_reg_q, head_reg_d;
   logic                 head_wre_q, head_wre_d;
   logic [DATA_W-1:0]    skid_data_q, skid_data_d;
   logic [RADDR_W-1:0]   skid_reg_q, skid_reg_d;
   logic                 skid_wre_q, skid_wre_d;
   logic [DATA_W-1:0]    in_data_s;
   logic                 push_s;
   logic                 pop_s;

   // Handshake and status decoded only from registered state.
   always_comb begin
      ready_out     = 1'b1;
      valid_out     = 1'b0;
      occupancy_out = 2'd0;
      case (state_q)
         ST_EMPTY: begin
            ready_out     = 1'b1;
            valid_out     = 1'b0;
            occupancy_out = 2'd0;
         end
         ST_ONE: begin
            ready_out     = 1'b1;
            valid_out     = 1'b1;
            occupancy_out = 2'd1;
         end
         ST_FULL: begin
            ready_out     = 1'b0;
            valid_out     = 1'b1;
            occupancy_out = 2'd2;
         end
         default: begin
            ready_out     = 1'b1;
            valid_out     = 1'b0;
            occupancy_out = 2'd0;
         end
      endcase
   end

   assign in_data_s     = wbs_in ? memData_in : calcData_in;
   assign push_s        = valid_in & ready_out;
   assign pop_s         = valid_out & ready_in;

   assign wb_data_out   = head_data_q;
   assign reg_dest_out  = head_reg_q;
   assign wre_out       = head_wre_q & valid_out;
   assign fwd_valid_out = head_wre_q & valid_out;
   assign fwd_reg_out   = head_reg_q;
   assign fwd_data_out  = head_data_q;

   // Next-state and storage update; flush overrides every transition.
   always_comb begin
      state_d     = state_q;
      head_data_d = head_data_q;
      head_reg_d  = head_reg_q;
      head_wre_d  = head_wre_q;
      skid_data_d = skid_data_q;
      skid_reg_d  = skid_reg_q;
      skid_wre_d  = skid_wre_q;
      if (flush_in) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (push_s) begin
                  head_data_d = in_data_s;
                  head_reg_d  = reg_dest_in;
                  head_wre_d  = wre_in;
                  state_d     = ST_ONE;
               end else begin
                  state_d = ST_EMPTY;
               end
            end
            ST_ONE: begin
               if (push_s && pop_s) begin
                  head_data_d = in_data_s;
                  head_reg_d  = reg_dest_in;
                  head_wre_d  = wre_in;
                  state_d     = ST_ONE;
               end else if (push_s) begin
                  skid_data_d = in_data_s;
                  skid_reg_d  = reg_dest_in;
                  skid_wre_d  = wre_in;
                  state_d     = ST_FULL;
               end else if (pop_s) begin
                  state_d = ST_EMPTY;
               end else begin
                  state_d = ST_ONE;
               end
            end
            ST_FULL: begin
               // The skid entry is younger, so it becomes the head on a pop.
               if (pop_s) begin
                  head_data_d = skid_data_q;
                  head_reg_d  = skid_reg_q;
                  head_wre_d  = skid_wre_q;
                  state_d     = ST_ONE;
               end else begin
                  state_d = ST_FULL;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
   end

   // State and storage registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         head_data_q <= {DATA_W{1'b0}};
         head_reg_q  <= {RADDR_W{1'b0}};
         head_wre_q  <= 1'b0;
         skid_data_q <= {DATA_W{1'b0}};
         skid_reg_q  <= {RADDR_W{1'b0}};
         skid_wre_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         head_data_q <= head_data_d;
         head_reg_q  <= head_reg_d;
         head_wre_q  <= head_wre_d;
         skid_data_q <= skid_data_d;
         skid_reg_q  <= skid_reg_d;
         skid_wre_q  <= skid_wre_d;
      end
   end

endmodule
